// File: rtl/nn_move_sequencer.sv
// ---------------------------------------------------------------------------
// nn_move_sequencer
//
// Consumes the 2-bit move decision of the neural network once per game tick,
// debounces it (CONFIRM identical consecutive samples), then steps a
// saturating lane position left or right and emits one-cycle pulses.
//
// Optional feature macro: NN_MOVE_COOLDOWN_EN
//   defined   -> COOL state plus cooldown counter; MOVE goes to COOL and the
//                next COOLDOWN ticks are ignored.
//   undefined -> no COOL state, no counter; MOVE goes straight to TRACK.
//
// Parameters:
//   LANES    number of lanes, lane index 0..LANES-1 (>= 2)
//   LANE_W   width of lane, must hold LANES-1
//   CONFIRM  identical tick samples required to commit (1..15)
//   COOLDOWN ticks ignored after a committed move (1..15, macro builds only)
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   en      in   enable; low forces IDLE
//   tick    in   one-cycle game-tick strobe
//   move    in   2'd0 left, 2'd1 stay, 2'd2 right, 2'd3 stay
//   lane    out  current lane index (registered)
//   step_l  out  one-cycle pulse when lane decrements
//   step_r  out  one-cycle pulse when lane increments
//   bump    out  one-cycle pulse when a committed move hits an edge
//   busy    out  high while in MOVE (and COOL)
//   agree   out  current agreement count
// ---------------------------------------------------------------------------
module nn_move_sequencer #(
    parameter int LANES    = 5,
    parameter int LANE_W   = 3,
    parameter int CONFIRM  = 3,
    parameter int COOLDOWN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              tick,
    input  logic [1:0]        move,
    output logic [LANE_W-1:0] lane,
    output logic              step_l,
    output logic              step_r,
    output logic              bump,
    output logic              busy,
    output logic [3:0]        agree
);

    // Elaboration-time guard against configurations the logic cannot honour.
    if (LANES < 2 || CONFIRM < 1 || CONFIRM > 15 || COOLDOWN < 1 ||
        COOLDOWN > 15 || (LANES - 1) >= (1 << LANE_W)) begin : g_bad_params
        $error("nn_move_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_MOVE  = 2'd2
`ifdef NN_MOVE_COOLDOWN_EN
        , S_COOL = 2'd3
`endif
    } state_e;

    typedef enum logic [1:0] {
        MV_LEFT  = 2'd0,
        MV_STAY  = 2'd1,
        MV_RIGHT = 2'd2
    } mv_e;

    localparam logic [3:0]        CONFIRM_4 = 4'(CONFIRM);
    localparam logic [LANE_W-1:0] LANE_MAX  = LANE_W'(LANES - 1);
    localparam logic [LANE_W-1:0] LANE_RST  = LANE_W'(LANES / 2);

    state_e            state_q, state_d;
    mv_e               cand_q, cand_d;
    mv_e               move_n;
    logic [3:0]        agree_q, agree_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              step_l_q, step_l_d;
    logic              step_r_q, step_r_d;
    logic              bump_q, bump_d;
    logic              busy_q, busy_d;
`ifdef NN_MOVE_COOLDOWN_EN
    localparam logic [3:0] COOL_INIT = 4'(COOLDOWN);
    logic [3:0]        cool_q, cool_d;
`endif

    // Code 3 is an alias of stay.
    always_comb begin
        case (move)
            2'd0:    move_n = MV_LEFT;
            2'd2:    move_n = MV_RIGHT;
            default: move_n = MV_STAY;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        cand_d   = cand_q;
        agree_d  = agree_q;
        lane_d   = lane_q;
        step_l_d = 1'b0;
        step_r_d = 1'b0;
        bump_d   = 1'b0;
`ifdef NN_MOVE_COOLDOWN_EN
        cool_d   = cool_q;
`endif

        if (!en) begin
            // Disable wins in every state, including a pending MOVE: the lane
            // holds and no pulse is produced.
            state_d = S_IDLE;
            agree_d = 4'd0;
            cand_d  = MV_STAY;
`ifdef NN_MOVE_COOLDOWN_EN
            cool_d  = 4'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    agree_d = 4'd0;
`ifdef NN_MOVE_COOLDOWN_EN
                    cool_d  = 4'd0;
`endif
                    state_d = S_TRACK;
                end

                S_TRACK: begin
                    if (tick) begin
                        if (move_n == cand_q) begin
                            agree_d = (agree_q >= CONFIRM_4) ? CONFIRM_4 : agree_q + 4'd1;
                        end else begin
                            cand_d  = move_n;
                            agree_d = 4'd1;
                        end
                        // Decision uses the freshly updated count/candidate so
                        // that the CONFIRM-th tick itself commits.
                        if (agree_d == CONFIRM_4) begin
                            if (cand_d == MV_STAY) begin
                                agree_d = 4'd0;
                            end else begin
                                state_d = S_MOVE;
                            end
                        end
                    end
                end

                S_MOVE: begin
                    // A tick in this cycle is deliberately not sampled.
                    if (cand_q == MV_LEFT && lane_q != '0) begin
                        lane_d   = lane_q - LANE_W'(1);
                        step_l_d = 1'b1;
                    end else if (cand_q == MV_RIGHT && lane_q < LANE_MAX) begin
                        lane_d   = lane_q + LANE_W'(1);
                        step_r_d = 1'b1;
                    end else begin
                        bump_d   = 1'b1;
                    end
                    agree_d = 4'd0;
`ifdef NN_MOVE_COOLDOWN_EN
                    cool_d  = COOL_INIT;
                    state_d = S_COOL;
`else
                    state_d = S_TRACK;
`endif
                end

`ifdef NN_MOVE_COOLDOWN_EN
                S_COOL: begin
                    if (tick) begin
                        if (cool_q <= 4'd1) begin
                            cool_d  = 4'd0;
                            agree_d = 4'd0;
                            cand_d  = MV_STAY;
                            state_d = S_TRACK;
                        end else begin
                            cool_d  = cool_q - 4'd1;
                        end
                    end
                end
`endif

                default: state_d = S_IDLE;
            endcase
        end

        // busy is registered from the next state so it rises on the edge
        // that enters MOVE and falls on the edge that leaves the busy states.
`ifdef NN_MOVE_COOLDOWN_EN
        busy_d = (state_d == S_MOVE) || (state_d == S_COOL);
`else
        busy_d = (state_d == S_MOVE);
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the block holds no memory arrays, so every flop is reset.
            state_q  <= S_IDLE;
            cand_q   <= MV_STAY;
            agree_q  <= 4'd0;
            lane_q   <= LANE_RST;
            step_l_q <= 1'b0;
            step_r_q <= 1'b0;
            bump_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef NN_MOVE_COOLDOWN_EN
            cool_q   <= 4'd0;
`endif
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            agree_q  <= agree_d;
            lane_q   <= lane_d;
            step_l_q <= step_l_d;
            step_r_q <= step_r_d;
            bump_q   <= bump_d;
            busy_q   <= busy_d;
`ifdef NN_MOVE_COOLDOWN_EN
            cool_q   <= cool_d;
`endif
        end
    end

    assign lane   = lane_q;
    assign step_l = step_l_q;
    assign step_r = step_r_q;
    assign bump   = bump_q;
    assign busy   = busy_q;
    assign agree  = agree_q;

endmodule

// File: tb/tb_nn_move_sequencer.sv
// ---------------------------------------------------------------------------
// tb_nn_move_sequencer
//
// Directed self-checking bench for nn_move_sequencer (LANES=5, CONFIRM=3,
// COOLDOWN=4). Expected pulses are queued when the committing tick is driven
// and compared by a negedge monitor in the cycle they must appear; every
// other cycle must show no pulse. Works with or without NN_MOVE_COOLDOWN_EN.
// ---------------------------------------------------------------------------
module tb_nn_move_sequencer;

    localparam int LANE_W = 3;
    localparam logic [2:0] P_L = 3'b001;  // {bump, step_r, step_l}
    localparam logic [2:0] P_R = 3'b010;
    localparam logic [2:0] P_B = 3'b100;

`ifdef NN_MOVE_COOLDOWN_EN
    localparam int BUSY_AFTER_MOVE = 1;
`else
    localparam int BUSY_AFTER_MOVE = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              tick;
    logic [1:0]        move;
    logic [LANE_W-1:0] lane;
    logic              step_l;
    logic              step_r;
    logic              bump;
    logic              busy;
    logic [3:0]        agree;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [2:0]        pulse;
        logic [LANE_W-1:0] lane;
        int                cyc;
    } exp_t;

    exp_t exp_q[$];

    logic [1:0] dith_mv  [6] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0};
    int         dith_agr [6] = '{1, 2, 1, 1, 2, 3};

    nn_move_sequencer #(
        .LANES   (5),
        .LANE_W  (LANE_W),
        .CONFIRM (3),
        .COOLDOWN(4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .tick  (tick),
        .move  (move),
        .lane  (lane),
        .step_l(step_l),
        .step_r(step_r),
        .bump  (bump),
        .busy  (busy),
        .agree (agree)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse is due in the cycle after the edge that follows the current one.
    task automatic expect_pulse(input logic [2:0] p, input int l);
        exp_t e;
        e.pulse = p;
        e.lane  = LANE_W'(l);
        e.cyc   = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; tick is sampled on the following posedge.
    task automatic tick_move(input logic [1:0] m);
        tick = 1'b1;
        move = m;
        @(negedge clk);
        tick = 1'b0;
        move = 2'd1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Consume the cooldown window (if present) after a committed move.
    task automatic cool();
`ifdef NN_MOVE_COOLDOWN_EN
        repeat (4) tick_move(2'd1);
`endif
        check("busy_after_move", 32'(busy), 0);
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the update.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            check("pulse", 32'({bump, step_r, step_l}), 32'(e.pulse));
            check("pulse_lane", 32'(lane), 32'(e.lane));
        end else begin
            check("no_pulse", 32'({bump, step_r, step_l}), 0);
        end
    end

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        tick = 1'b0;
        move = 2'd1;

        // Reset and enable
        idle(2);
        check("rst_lane", 32'(lane), 2);
        check("rst_agree", 32'(agree), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        en  = 1'b1;
        idle(3);
        check("en_lane", 32'(lane), 2);
        check("en_agree", 32'(agree), 0);
        check("en_busy", 32'(busy), 0);

        // Confirmed right, back-to-back ticks
        tick_move(2'd2); check("r_agree1", 32'(agree), 1);
        tick_move(2'd2); check("r_agree2", 32'(agree), 2);
        tick_move(2'd2); check("r_agree3", 32'(agree), 3);
        check("r_busy_rise", 32'(busy), 1);
        check("r_lane_hold", 32'(lane), 2);
        expect_pulse(P_R, 3);
        tick_move(2'd2);                      // lands in the MOVE cycle
        check("r_lane3", 32'(lane), 3);
        check("r_agree_clr", 32'(agree), 0);
        check("r_busy_move", 32'(busy), BUSY_AFTER_MOVE);
`ifdef NN_MOVE_COOLDOWN_EN
        repeat (3) tick_move(2'd2);
        check("cool_busy_hold", 32'(busy), 1);
        check("cool_lane_hold", 32'(lane), 3);
        tick_move(2'd2);
        check("cool_busy_exit", 32'(busy), 0);
        check("cool_agree", 32'(agree), 0);
`endif
        tick_move(2'd2); check("r2_agree1", 32'(agree), 1);
        tick_move(2'd2); check("r2_agree2", 32'(agree), 2);
        tick_move(2'd2); expect_pulse(P_R, 4);
        idle(1);
        check("r_lane4", 32'(lane), 4);
        cool();

        // Right edge saturation
        repeat (3) tick_move(2'd2);
        expect_pulse(P_B, 4);
        idle(1);
        check("bump_r_lane", 32'(lane), 4);
        cool();

        // Plain reset back to the centre lane
        rst = 1'b1;
        idle(1);
        check("rst2_lane", 32'(lane), 2);
        rst = 1'b0;
        idle(1);

        // Dithering input
        for (int i = 0; i < 6; i++) begin
            tick_move(dith_mv[i]);
            check($sformatf("dith_agree%0d", i), 32'(agree), 32'(dith_agr[i]));
        end
        expect_pulse(P_L, 1);
        idle(1);
        check("dith_lane", 32'(lane), 1);
        cool();

        // Left edge saturation
        repeat (3) tick_move(2'd0);
        expect_pulse(P_L, 0);
        idle(1);
        check("l_lane0", 32'(lane), 0);
        cool();
        repeat (3) tick_move(2'd0);
        expect_pulse(P_B, 0);
        idle(1);
        check("bump_l_lane", 32'(lane), 0);
        cool();

        // Stay and code 3
        tick_move(2'd1); check("stay_agree1", 32'(agree), 1);
        tick_move(2'd3); check("stay_agree2", 32'(agree), 2);
        tick_move(2'd1); check("stay_agree0", 32'(agree), 0);
        repeat (2) tick_move(2'd3);
        check("c3_agree2", 32'(agree), 2);
        tick_move(2'd3);
        check("c3_agree0", 32'(agree), 0);
        check("c3_busy", 32'(busy), 0);
        check("c3_lane", 32'(lane), 0);

        // Disable in the MOVE cycle
        repeat (3) tick_move(2'd2);
        check("dis_busy_pre", 32'(busy), 1);
        en = 1'b0;
        idle(1);
        check("dis_lane", 32'(lane), 0);
        check("dis_busy", 32'(busy), 0);
        check("dis_agree", 32'(agree), 0);
        tick_move(2'd2);                      // ignored while disabled
        check("dis_idle_agree", 32'(agree), 0);
        en = 1'b1;
        idle(1);
        repeat (3) tick_move(2'd2);
        expect_pulse(P_R, 1);
        idle(1);
        check("reen_lane", 32'(lane), 1);
        cool();

        // Reset in the MOVE cycle
        repeat (3) tick_move(2'd0);
        check("rstm_lane_pre", 32'(lane), 1);
        rst = 1'b1;
        idle(1);
        check("rstm_lane", 32'(lane), 2);
        check("rstm_busy", 32'(busy), 0);
        check("rstm_agree", 32'(agree), 0);
        rst = 1'b0;

`ifdef NN_MOVE_COOLDOWN_EN
        // Reset during COOL
        idle(1);
        repeat (3) tick_move(2'd0);
        expect_pulse(P_L, 1);
        idle(1);
        check("rstc_busy_pre", 32'(busy), 1);
        tick_move(2'd1);
        rst = 1'b1;
        idle(1);
        check("rstc_lane", 32'(lane), 2);
        check("rstc_busy", 32'(busy), 0);
        rst = 1'b0;
`endif

        idle(3);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nn_move_sequencer.md
# nn_move_sequencer

Downstream consumer of the neural-network move decision. Samples the 2-bit `move` code on each game tick, requires `CONFIRM` consecutive identical samples before acting, then steps a saturating lane position left or right and emits one-cycle step/bump pulses to the game and display logic. An optional cooldown keeps the player from moving on every tick while the network output dithers.

## Interface
- `LANES`, 5, number of lanes; lane index range 0..LANES-1 (LANES ≥ 2)
- `LANE_W`, 3, width of `lane`; must hold LANES-1
- `CONFIRM`, 3, consecutive identical tick samples required to commit (1..15)
- `COOLDOWN`, 4, ticks ignored after a committed move (1..15; used only with the cooldown macro)

- `clk` in 1: system clock; all state changes on the rising edge
- `rst` in 1: synchronous, active-high reset
- `en` in 1: sequencer enable; low forces IDLE
- `tick` in 1: one-cycle game-tick strobe
- `move` in 2: network decision; 0 = left, 1 = stay, 2 = right, 3 = stay
- `lane` out LANE_W: current lane index
- `step_l` out 1: one-cycle pulse when the lane decrements
- `step_r` out 1: one-cycle pulse when the lane increments
- `bump` out 1: one-cycle pulse when a committed move is blocked at an edge
- `busy` out 1: high in MOVE and COOL
- `agree` out 4: current agreement count, for display

## Operation
- Reset values: `lane` = LANES/2 (integer division, so 2 by default), `step_l` = `step_r` = `bump` = 0, `busy` = 0, `agree` = 0, state = IDLE, candidate = stay, cooldown counter = 0.
- States are IDLE, TRACK, MOVE and COOL.
- **IDLE:** counters are held at 0. If `en` = 1, go to TRACK on the next edge.
- **TRACK:** on each edge with `tick` = 1:
  - If `move` (3 mapped to 1) equals the candidate, `agree` increments, saturating at CONFIRM.
  - Otherwise the candidate becomes `move` and `agree` becomes 1.
  - When the updated `agree` equals CONFIRM and the candidate is left or right, go to MOVE.
  - When the updated `agree` equals CONFIRM and the candidate is stay, clear `agree` to 0 and remain in TRACK.
- **MOVE:** lasts exactly one cycle.
  - Left with `lane` > 0: decrement `lane` and pulse `step_l`.
  - Right with `lane` < LANES-1: increment `lane` and pulse `step_r`.
  - Otherwise (move blocked at an edge): `lane` is unchanged and `bump` pulses.
  - Clear `agree`, then go to COOL (macro defined) or TRACK (macro undefined).
  - A `tick` arriving in this cycle is dropped.
- **COOL:** the counter is loaded with COOLDOWN on entry and decrements on each `tick`. When it reaches 0, go to TRACK with `agree` = 0 and candidate = stay. Ticks during COOL are not sampled.
- `en` = 0 in any state forces IDLE on the next edge and clears `agree`, the candidate and the cooldown counter. `lane` holds its value. A MOVE cycle coinciding with `en` = 0 does not update `lane` and emits no pulses.
- `rst` has priority over `en` and `tick`. Reset during MOVE or COOL restores all reset values on that edge.
- `step_l`, `step_r` and `bump` are mutually exclusive and are never high for two consecutive cycles.

## Timing
- All outputs are registered.
- Let edge E be the one that samples the CONFIRM-th agreeing tick. The state is MOVE in the cycle after E. `lane` and the step/bump pulse change at edge E+1 and are visible for one cycle.
- Committing a move therefore takes 2 edges after the final tick.
- Minimum tick-to-tick spacing: 1 cycle. Back-to-back ticks are all counted in TRACK.
- `busy` rises at edge E and falls on the edge that leaves COOL (or at E+1 without the macro).
- Leaving COOL takes COOLDOWN ticks after MOVE.

## Configuration
- `NN_MOVE_COOLDOWN_EN` defined: COOL state and the cooldown counter are present; MOVE → COOL.
- `NN_MOVE_COOLDOWN_EN` undefined: there is no COOL state and no counter; MOVE → TRACK directly. The COOLDOWN parameter is ignored and `busy` is high only in MOVE.

## Test plan
- **Reset and enable:** assert reset, then `en` = 1 with no ticks → `lane` = 2, `agree` = 0, no pulses.
- **Confirmed right:** `move` = 2 on 3 consecutive ticks → `step_r` pulses once 2 edges after the 3rd tick; `lane` = 3. With the macro, 4 further `move` = 2 ticks are ignored; the next 3 ticks give `lane` = 4.
- **Dithering input:** `move` sequence 0, 0, 2, 0, 0, 0 on ticks → exactly one `step_l`, 2 edges after the 6th tick; `lane` = 1; `agree` shows 1, 2, 1, 1, 2, 3.
- **Edge saturation:** drive `lane` to 0, then `move` = 0 three times → `bump` pulses, `lane` stays 0, no `step_l`.
- **Stay and code 3:** `move` = 1, 3, 1 on ticks → no pulse and `agree` returns to 0. Then `move` = 3 on 3 ticks → still no pulse.
- **Disable and reset mid-operation:** deassert `en` in the MOVE cycle → no pulse, `lane` unchanged, state IDLE. Assert `rst` during COOL → `lane` = 2, `busy` = 0 on the next edge.
